// File: rtl/top_level_modelsim.sv
// top_level_modelsim
//   Microprogrammed 16-bit datapath driven directly by control-word inputs:
//   8x16 register file, ALU with flags, data RAM, LIFO stack, PC and IR.
//   One control word executes one micro-op per rising edge of clock_50.
//   Optional feature macro: STACK_EN (defined = LIFO stack present,
//   undefined = no stack storage, SS ignored, stack writeback reads as 0).
module top_level_modelsim #(
   parameter int DMEM_AW     = 8,
   parameter int STACK_DEPTH = 8
) (
   input  logic        clock_50,
   input  logic        clear,
   input  logic        WR,
   input  logic        MW,
   input  logic        MA,
   input  logic        IR_L,
   input  logic        Cin,
   input  logic [2:0]  AA,
   input  logic [2:0]  BA,
   input  logic [2:0]  DA,
   input  logic [4:0]  FS,
   input  logic [15:0] k,
   input  logic [4:0]  MD,
   input  logic [1:0]  PS,
   input  logic [1:0]  SS,
   output logic        Cout,
   output logic        Z,
   output logic        N,
   output logic [15:0] R0,
   output logic [15:0] R1,
   output logic [15:0] R2,
   output logic [15:0] R3,
   output logic [15:0] R4,
   output logic [15:0] R5,
   output logic [15:0] R6,
   output logic [15:0] R7
);

   // ALU function codes
   localparam logic [4:0] FS_ZERO    = 5'b00000;
   localparam logic [4:0] FS_AND     = 5'b01000;
   localparam logic [4:0] FS_OR      = 5'b01110;
   localparam logic [4:0] FS_XOR     = 5'b00110;
   localparam logic [4:0] FS_PASS_A  = 5'b01100;
   localparam logic [4:0] FS_PASS_B  = 5'b01010;
   localparam logic [4:0] FS_ONES    = 5'b01111;
   localparam logic [4:0] FS_NOT_A   = 5'b10001;
   localparam logic [4:0] FS_INC_A   = 5'b10010;
   localparam logic [4:0] FS_NEG_A   = 5'b10011;
   localparam logic [4:0] FS_ADD     = 5'b10100;
   localparam logic [4:0] FS_SUB     = 5'b10110;
   localparam logic [4:0] FS_SHL     = 5'b11000;
   localparam logic [4:0] FS_SHR     = 5'b11001;

   // Writeback select codes (one-hot)
   localparam logic [4:0] MD_PC      = 5'b00001;
   localparam logic [4:0] MD_FLAGS   = 5'b00010;
   localparam logic [4:0] MD_F       = 5'b00100;
   localparam logic [4:0] MD_RAM     = 5'b01000;
   localparam logic [4:0] MD_STACK   = 5'b10000;

   // PC control codes
   localparam logic [1:0] PS_HOLD    = 2'b00;
   localparam logic [1:0] PS_INC     = 2'b01;
   localparam logic [1:0] PS_JUMP    = 2'b10;
   localparam logic [1:0] PS_REL     = 2'b11;

   // Stack control codes
   localparam logic [1:0] SS_PUSH    = 2'b01;
   localparam logic [1:0] SS_POP     = 2'b10;

   localparam int DMEM_WORDS = 2 ** DMEM_AW;

   // Architectural state
   logic [15:0] rf_reg [8];
   logic [15:0] pc_reg;
   logic [15:0] pc_next;
   logic [15:0] ir_reg;
   logic [15:0] dmem [DMEM_WORDS];

   // Datapath buses
   logic [15:0]        a_bus;
   logic [15:0]        b_bus;
   logic [15:0]        f_bus;
   logic [15:0]        d_bus;
   logic [15:0]        ram_rdata;
   logic [15:0]        stack_top;
   logic [16:0]        sum17;
   logic               arith;
   logic [DMEM_AW-1:0] dmem_addr;

   // Operand fetch: register reads are asynchronous and see the pre-edge
   // contents, so a write to the same register this cycle is not bypassed.
   assign a_bus     = rf_reg[AA];
   assign b_bus     = MA ? k : rf_reg[BA];
   assign dmem_addr = b_bus[DMEM_AW-1:0];
   assign ram_rdata = dmem[dmem_addr];

   // ALU: logic ops, shifts and a 17-bit adder whose top bit is the carry
   always_comb begin
      f_bus = '0;
      sum17 = '0;
      arith = 1'b0;
      case (FS)
         FS_ZERO:   f_bus = '0;
         FS_AND:    f_bus = a_bus & b_bus;
         FS_OR:     f_bus = a_bus | b_bus;
         FS_XOR:    f_bus = a_bus ^ b_bus;
         FS_PASS_A: f_bus = a_bus;
         FS_PASS_B: f_bus = b_bus;
         FS_ONES:   f_bus = 16'hFFFF;
         FS_NOT_A:  f_bus = ~a_bus;
         FS_INC_A: begin
            arith = 1'b1;
            sum17 = {1'b0, a_bus} + 17'd1;
         end
         FS_NEG_A: begin
            arith = 1'b1;
            sum17 = {1'b0, ~a_bus} + {16'b0, Cin};
         end
         FS_ADD: begin
            arith = 1'b1;
            sum17 = {1'b0, a_bus} + {1'b0, b_bus} + {16'b0, Cin};
         end
         FS_SUB: begin
            arith = 1'b1;
            sum17 = {1'b0, a_bus} + {1'b0, ~b_bus} + {16'b0, Cin};
         end
         FS_SHL:    f_bus = {b_bus[14:0], 1'b0};
         FS_SHR:    f_bus = {1'b0, b_bus[15:1]};
         default:   f_bus = '0;
      endcase
      if (arith) begin
         f_bus = sum17[15:0];
      end
   end

   // Flags are purely combinational views of the current ALU result
   assign Cout = arith & sum17[16];
   assign Z    = (f_bus == 16'h0000);
   assign N    = f_bus[15];

   // Writeback mux; anything that is not a clean one-hot code falls back to F
   always_comb begin
      d_bus = f_bus;
      case (MD)
         MD_PC:    d_bus = pc_reg;
         MD_FLAGS: d_bus = {13'b0, N, Z, Cout};
         MD_F:     d_bus = f_bus;
         MD_RAM:   d_bus = ram_rdata;
         MD_STACK: d_bus = stack_top;
         default:  d_bus = f_bus;
      endcase
   end

   // Register file: clear wins over any write
   always_ff @(posedge clock_50) begin
      if (clear) begin
         for (int i = 0; i < 8; i++) begin
            rf_reg[i] <= '0;
         end
      end else if (WR) begin
         rf_reg[DA] <= d_bus;
      end
   end

   assign R0 = rf_reg[0];
   assign R1 = rf_reg[1];
   assign R2 = rf_reg[2];
   assign R3 = rf_reg[3];
   assign R4 = rf_reg[4];
   assign R5 = rf_reg[5];
   assign R6 = rf_reg[6];
   assign R7 = rf_reg[7];

   // PC next-value selection; all arithmetic wraps at 16 bits
   always_comb begin
      pc_next = pc_reg;
      case (PS)
         PS_HOLD: pc_next = pc_reg;
         PS_INC:  pc_next = pc_reg + 16'd1;
         PS_JUMP: pc_next = a_bus;
         PS_REL:  pc_next = pc_reg + k;
         default: pc_next = pc_reg;
      endcase
   end

   // PC and IR registers
   always_ff @(posedge clock_50) begin
      if (clear) begin
         pc_reg <= '0;
         ir_reg <= '0;
      end else begin
         pc_reg <= pc_next;
         if (IR_L) begin
            ir_reg <= k;
         end
      end
   end

   // Data RAM: asynchronous read, write of A at address B. Contents survive
   // clear, but a write presented together with clear is suppressed.
   always_ff @(posedge clock_50) begin
      if (!clear && MW) begin
         dmem[dmem_addr] <= a_bus;
      end
   end

`ifdef STACK_EN
   localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
   localparam int              SI_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

   logic [15:0]     stack_reg [STACK_DEPTH];
   logic [SP_W-1:0] sp_reg;
   logic [SP_W-1:0] sp_dec;
   logic [SI_W-1:0] push_idx;
   logic [SI_W-1:0] top_idx;

   // SP counts occupied entries; the top entry lives at SP-1
   assign sp_dec    = sp_reg - SP_ONE;
   assign push_idx  = sp_reg[SI_W-1:0];
   assign top_idx   = sp_dec[SI_W-1:0];
   assign stack_top = (sp_reg != '0) ? stack_reg[top_idx] : 16'h0000;

   // LIFO update: push when full and pop when empty leave the stack unchanged
   always_ff @(posedge clock_50) begin
      if (clear) begin
         sp_reg <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_reg[i] <= '0;
         end
      end else begin
         case (SS)
            SS_PUSH: begin
               if (sp_reg != SP_FULL) begin
                  stack_reg[push_idx] <= f_bus;
                  sp_reg              <= sp_reg + SP_ONE;
               end
            end
            SS_POP: begin
               if (sp_reg != '0) begin
                  sp_reg <= sp_dec;
               end
            end
            default: ;
         endcase
      end
   end
`else
   // No stack storage: the stack writeback source always reads zero
   assign stack_top = 16'h0000;
`endif

endmodule

// File: tb/tb_top_level_modelsim.sv
// tb_top_level_modelsim
//   Directed self-checking bench for the control-word datapath. Expected
//   values are hand-computed; stack results depend on whether STACK_EN is set.
module tb_top_level_modelsim;

   logic        clock_50 = 1'b0;
   logic        clear;
   logic        WR;
   logic        MW;
   logic        MA;
   logic        IR_L;
   logic        Cin;
   logic [2:0]  AA;
   logic [2:0]  BA;
   logic [2:0]  DA;
   logic [4:0]  FS;
   logic [15:0] k;
   logic [4:0]  MD;
   logic [1:0]  PS;
   logic [1:0]  SS;
   logic        Cout;
   logic        Z;
   logic        N;
   logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;

   int checks = 0;
   int errors = 0;

`ifdef STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   always #5 clock_50 = ~clock_50;

   top_level_modelsim dut (
      .clock_50 (clock_50),
      .clear    (clear),
      .WR       (WR),
      .MW       (MW),
      .MA       (MA),
      .IR_L     (IR_L),
      .Cin      (Cin),
      .AA       (AA),
      .BA       (BA),
      .DA       (DA),
      .FS       (FS),
      .k        (k),
      .MD       (MD),
      .PS       (PS),
      .SS       (SS),
      .Cout     (Cout),
      .Z        (Z),
      .N        (N),
      .R0       (R0),
      .R1       (R1),
      .R2       (R2),
      .R3       (R3),
      .R4       (R4),
      .R5       (R5),
      .R6       (R6),
      .R7       (R7)
   );

   function automatic logic [15:0] rd(input int i);
      case (i)
         0: rd = R0;
         1: rd = R1;
         2: rd = R2;
         3: rd = R3;
         4: rd = R4;
         5: rd = R5;
         6: rd = R6;
         default: rd = R7;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
         $display("check %-12s observed %h expected %h ok", tag, obs, exp);
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      clear = 1'b0; WR = 1'b0; MW = 1'b0; MA = 1'b0; IR_L = 1'b0; Cin = 1'b0;
      AA = 3'd0; BA = 3'd0; DA = 3'd0; FS = 5'b00000; k = 16'h0000;
      MD = 5'b00100; PS = 2'b00; SS = 2'b00;
   endtask

   task automatic tick();
      @(posedge clock_50);
      #1;
   endtask

   initial begin
      logic [15:0] val;

      // Reset
      idle(); clear = 1'b1; tick();
      for (int i = 0; i < 8; i++) chk($sformatf("reset_R%0d", i), rd(i), 16'h0000);
      chk("reset_Z", {15'b0, Z}, 16'h0001);
      chk("reset_N", {15'b0, N}, 16'h0000);
      chk("reset_Cout", {15'b0, Cout}, 16'h0000);

      // Arithmetic sequence
      idle(); MA = 1'b1; k = 16'h000F; FS = 5'b01010; DA = 3'd0; WR = 1'b1; tick();
      chk("ldi_R0", R0, 16'h000F);
      idle(); FS = 5'b10010; AA = 3'd0; DA = 3'd1; WR = 1'b1; tick();
      chk("inc_R1", R1, 16'h0010);
      idle(); FS = 5'b10100; AA = 3'd0; BA = 3'd1; DA = 3'd2; WR = 1'b1; #1;
      chk("add_Cout", {15'b0, Cout}, 16'h0000);
      chk("add_Z", {15'b0, Z}, 16'h0000);
      tick(); chk("add_R2", R2, 16'h001F);
      idle(); FS = 5'b10110; AA = 3'd1; BA = 3'd0; DA = 3'd3; Cin = 1'b1; WR = 1'b1; #1;
      chk("sub_Cout", {15'b0, Cout}, 16'h0001);
      tick(); chk("sub_R3", R3, 16'h0001);
      idle(); FS = 5'b10011; AA = 3'd0; Cin = 1'b1; DA = 3'd0; WR = 1'b1; #1;
      chk("neg_N", {15'b0, N}, 16'h0001);
      chk("neg_Cout", {15'b0, Cout}, 16'h0000);
      tick(); chk("neg_R0", R0, 16'hFFF1);

      // Shifts pushed onto the stack, then popped back
      idle(); FS = 5'b11001; BA = 3'd0; SS = 2'b01; #1;
      chk("shr_N", {15'b0, N}, 16'h0000);
      tick();
      idle(); FS = 5'b11000; BA = 3'd0; SS = 2'b01; #1;
      chk("shl_N", {15'b0, N}, 16'h0001);
      tick();
      idle(); MD = 5'b10000; SS = 2'b10; DA = 3'd0; WR = 1'b1; tick();
      chk("pop1_R0", R0, STK ? 16'hFFE2 : 16'h0000);
      idle(); MD = 5'b10000; SS = 2'b10; DA = 3'd1; WR = 1'b1; tick();
      chk("pop2_R1", R1, STK ? 16'h7FF8 : 16'h0000);
      idle(); MD = 5'b10000; SS = 2'b10; DA = 3'd2; WR = 1'b1; tick();
      chk("pop_empty", R2, 16'h0000);

      // Store / load through data RAM
      idle(); MA = 1'b1; k = 16'h1234; FS = 5'b01010; DA = 3'd0; WR = 1'b1; IR_L = 1'b1; tick();
      chk("ldi_1234", R0, 16'h1234);
      idle(); AA = 3'd0; MA = 1'b1; k = 16'h0000; MW = 1'b1; tick();
      idle(); MD = 5'b01000; DA = 3'd1; MA = 1'b1; k = 16'h0000; WR = 1'b1; tick();
      chk("ld_R1", R1, 16'h1234);

      // Zero-result subtract with flags writeback, then OR immediate
      idle(); MA = 1'b1; k = 16'h0005; FS = 5'b01010; DA = 3'd4; WR = 1'b1; tick();
      chk("ldi_R4", R4, 16'h0005);
      idle(); MA = 1'b1; k = 16'h001F; FS = 5'b01010; DA = 3'd2; WR = 1'b1; tick();
      chk("ldi_R2", R2, 16'h001F);
      idle(); FS = 5'b10110; AA = 3'd4; BA = 3'd4; Cin = 1'b1; MD = 5'b00010; DA = 3'd5; WR = 1'b1; #1;
      chk("subz_Z", {15'b0, Z}, 16'h0001);
      chk("subz_Cout", {15'b0, Cout}, 16'h0001);
      tick(); chk("flags_R5", R5, 16'h0003);
      idle(); FS = 5'b01110; AA = 3'd2; MA = 1'b1; k = 16'hF000; DA = 3'd6; WR = 1'b1; #1;
      chk("ori_N", {15'b0, N}, 16'h0001);
      chk("ori_Z", {15'b0, Z}, 16'h0000);
      tick(); chk("ori_R6", R6, 16'hF01F);

      // Logic ops
      idle(); FS = 5'b01000; AA = 3'd6; MA = 1'b1; k = 16'h0FF0; DA = 3'd3; WR = 1'b1; tick();
      chk("and_R3", R3, 16'h0010);
      idle(); FS = 5'b00110; AA = 3'd6; MA = 1'b1; k = 16'hFFFF; DA = 3'd4; WR = 1'b1; tick();
      chk("xor_R4", R4, 16'h0FE0);
      idle(); FS = 5'b10001; AA = 3'd3; DA = 3'd5; WR = 1'b1; tick();
      chk("not_R5", R5, 16'hFFEF);

      // PC: increment, relative, jump with wrap
      idle(); PS = 2'b01; tick(); tick();
      idle(); PS = 2'b11; k = 16'h0010; tick();
      idle(); MD = 5'b00001; DA = 3'd7; WR = 1'b1; tick();
      chk("pc_rel", R7, 16'h0012);
      idle(); PS = 2'b10; AA = 3'd6; tick();
      idle(); PS = 2'b11; k = 16'hFFE2; tick();
      idle(); MD = 5'b00001; DA = 3'd7; WR = 1'b1; tick();
      chk("pc_wrap", R7, 16'hF001);

      // Non-one-hot MD selects F; unlisted FS gives zero
      idle(); FS = 5'b01111; MD = 5'b00011; DA = 3'd7; WR = 1'b1; #1;
      chk("ones_Cout", {15'b0, Cout}, 16'h0000);
      tick(); chk("md_bad_R7", R7, 16'hFFFF);
      idle(); FS = 5'b00001; AA = 3'd7; BA = 3'd7; #1;
      chk("fs_bad_Z", {15'b0, Z}, 16'h0001);

      // Clear together with WR, MW, SS push and PS increment
      idle(); FS = 5'b01111; SS = 2'b01; tick();
      idle(); clear = 1'b1; WR = 1'b1; DA = 3'd0; FS = 5'b01111; SS = 2'b01;
      MW = 1'b1; MA = 1'b1; k = 16'h0000; AA = 3'd7; PS = 2'b01; tick();
      for (int i = 0; i < 8; i++) chk($sformatf("clr_R%0d", i), rd(i), 16'h0000);
      idle(); FS = 5'b01111; MD = 5'b10000; SS = 2'b10; DA = 3'd0; WR = 1'b1; tick();
      chk("clr_sp", R0, 16'h0000);
      idle(); MD = 5'b00001; DA = 3'd1; WR = 1'b1; tick();
      chk("clr_pc", R1, 16'h0000);
      idle(); MD = 5'b01000; MA = 1'b1; k = 16'h0000; DA = 3'd2; WR = 1'b1; tick();
      chk("clr_ram", R2, 16'h1234);

      // Nine pushes: the ninth is dropped, then LIFO pops
      for (int i = 0; i < 9; i++) begin
         idle(); FS = 5'b01010; MA = 1'b1; val = 16'h0100 + 16'(i); k = val; SS = 2'b01; tick();
      end
      for (int i = 0; i < 8; i++) begin
         idle(); MD = 5'b10000; SS = 2'b10; DA = 3'd3; WR = 1'b1; tick();
         val = 16'h0107 - 16'(i);
         chk($sformatf("lifo_%0d", i), R3, STK ? val : 16'h0000);
      end
      idle(); MD = 5'b10000; SS = 2'b10; DA = 3'd3; WR = 1'b1; tick();
      chk("lifo_empty", R3, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
